// File: rtl/sprite_pkg.sv
// Shared types, display defaults and per-sprite constants for the sprite motion scheduler.
package sprite_pkg;

    localparam int unsigned POS_W        = 10;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned SPRITE_W_DEF = 16;
    localparam int unsigned SPRITE_H_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic             dx;
        logic             dy;
    } sprite_t;

    // Sprite i moves i+1 pixels per step on each axis.
    function automatic logic [POS_W-1:0] speed(input logic [POS_W-1:0] i);
        return i + POS_W'(1);
    endfunction

    // Sprite i starts on the diagonal at 32*i.
    function automatic logic [POS_W-1:0] reset_pos(input logic [POS_W-1:0] i);
        return POS_W'(i << 5);
    endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis bounce: advance a coordinate by v and reflect off 0 or max.
module sprite_axis_step
    import sprite_pkg::*;
(
    input  logic [POS_W-1:0] p,
    input  logic             dir,
    input  logic [POS_W-1:0] v,
    input  logic [POS_W-1:0] max,
    output logic [POS_W-1:0] p_next,
    output logic             dir_next
);

    logic [POS_W:0] sum;

    // Extra bit keeps p+v from wrapping before the edge compare.
    always_comb begin
        sum      = {1'b0, p} + {1'b0, v};
        p_next   = p;
        dir_next = dir;
        if (dir) begin
            if (sum >= {1'b0, max}) begin
                p_next   = max;
                dir_next = 1'b0;
            end else begin
                p_next = sum[POS_W-1:0];
            end
        end else begin
            if (p <= v) begin
                p_next   = '0;
                dir_next = 1'b1;
            end else begin
                p_next = p - v;
            end
        end
    end

endmodule

// File: rtl/sprite_motion_scheduler.sv
// Frame-synchronous scheduler stepping NUM_SPRITES bouncing sprites through one shared datapath.
module sprite_motion_scheduler
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned SPRITE_W    = SPRITE_W_DEF,
    parameter int unsigned SPRITE_H    = SPRITE_H_DEF,
    parameter int unsigned DIV_WIDTH   = 4,
    localparam int unsigned IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] frames_per_step,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [POS_W-1:0]     rd_x,
    output logic [POS_W-1:0]     rd_y,
    output logic                 busy,
    output logic                 step_done,
    output logic                 overrun
);

    localparam logic [POS_W-1:0] X_MAX  = POS_W'(H_ACTIVE - SPRITE_W);
    localparam logic [POS_W-1:0] Y_MAX  = POS_W'(V_ACTIVE - SPRITE_H);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_SPRITES - 1);

    sprite_t              spr [NUM_SPRITES];
    sprite_t              work;
    state_t               state;
    state_t               next_state;
    logic [IDX_W-1:0]     k;
    logic [DIV_WIDTH-1:0] cnt;
    logic                 step_go;
    logic [POS_W-1:0]     vel;
    logic [POS_W-1:0]     nx;
    logic [POS_W-1:0]     ny;
    logic                 ndx;
    logic                 ndy;
    logic [POS_W-1:0]     sel_x;
    logic [POS_W-1:0]     sel_y;

    // A late divider shrink still triggers a step once cnt has passed it.
    assign step_go = (cnt >= frames_per_step);
    assign vel     = speed(POS_W'(k));

    sprite_axis_step u_step_x (
        .p        (work.x),
        .dir      (work.dx),
        .v        (vel),
        .max      (X_MAX),
        .p_next   (nx),
        .dir_next (ndx)
    );

    sprite_axis_step u_step_y (
        .p        (work.y),
        .dir      (work.dy),
        .v        (vel),
        .max      (Y_MAX),
        .p_next   (ny),
        .dir_next (ndy)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state: one FETCH/UPDATE pair per sprite, then a single DONE cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (frame_tick && run && step_go) next_state = FETCH;
            FETCH:   next_state = UPDATE;
            UPDATE:  next_state = (k == K_LAST) ? DONE : FETCH;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status decode; overrun flags a tick landing while a sequence is running.
    always_comb begin
        busy      = (state != IDLE);
        step_done = (state == DONE);
        overrun   = frame_tick && (state != IDLE);
    end

    // Frame divider, sprite index, working copy and sprite array write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            k    <= '0;
            work <= '0;
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                spr[i] <= '{x: reset_pos(POS_W'(i)), y: reset_pos(POS_W'(i)), dx: 1'b1, dy: 1'b1};
            end
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick && run) begin
                        if (step_go) begin
                            cnt <= '0;
                            k   <= '0;
                        end else begin
                            cnt <= cnt + DIV_WIDTH'(1);
                        end
                    end
                end
                FETCH: work <= spr[k];
                UPDATE: begin
                    spr[k] <= '{x: nx, y: ny, dx: ndx, dy: ndy};
                    if (k != K_LAST) k <= k + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Read mux; indices beyond the last sprite select zero.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                sel_x = spr[i].x;
                sel_y = spr[i].y;
            end
        end
    end

    // Registered read port; a same-cycle write-back is seen one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_x <= '0;
            rd_y <= '0;
        end else begin
            rd_x <= sel_x;
            rd_y <= sel_y;
        end
    end

endmodule

// File: tb/tb_sprite_motion_scheduler.sv
// Directed bench for sprite_motion_scheduler (4-sprite main instance plus a 3-sprite instance).
module tb_sprite_motion_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       run;
    logic [3:0] fps;
    logic [1:0] rd_idx;
    logic [9:0] rd_x, rd_y, rd_x3, rd_y3;
    logic       busy, step_done, overrun;
    logic       busy3, done3, ovr3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sprite_motion_scheduler #(.NUM_SPRITES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .run             (run),
        .frames_per_step (fps),
        .rd_idx          (rd_idx),
        .rd_x            (rd_x),
        .rd_y            (rd_y),
        .busy            (busy),
        .step_done       (step_done),
        .overrun         (overrun)
    );

    sprite_motion_scheduler #(.NUM_SPRITES(3)) dut3 (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .run             (run),
        .frames_per_step (fps),
        .rd_idx          (rd_idx),
        .rd_x            (rd_x3),
        .rd_y            (rd_y3),
        .busy            (busy3),
        .step_done       (done3),
        .overrun         (ovr3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic read_pos(input logic [1:0] idx, output logic [9:0] x, output logic [9:0] y);
        rd_idx = idx;
        tick();
        x = rd_x;
        y = rd_y;
    endtask

    task automatic pulse(input int cycles, output int dones, output int busy_cyc);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        dones    = 0;
        busy_cyc = 0;
        for (int i = 0; i < cycles; i++) begin
            if (busy) busy_cyc++;
            if (step_done) dones++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_tick = 1'b0; run = 1'b0; fps = 4'd0; rd_idx = 2'd1;
        tick();
        tick();
        n_checks++;
        if ({busy, step_done, overrun} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, step_done, overrun});
        else n_pass++;
        n_checks++;
        if ({rd_x, rd_y} !== 20'd0) $display("FAIL reset_rd: got %0d,%0d expected 0,0", rd_x, rd_y);
        else n_pass++;
        n_checks++;
        if ({busy3, done3, ovr3} !== 3'b000) $display("FAIL reset_flags3: got %b expected 000", {busy3, done3, ovr3});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_read_port();
        logic [9:0] x, y;
        read_pos(2'd1, x, y);
        n_checks++;
        if (x !== 10'd32 || y !== 10'd32) $display("FAIL rd_sprite1: got %0d,%0d expected 32,32", x, y);
        else n_pass++;
        read_pos(2'd3, x, y);
        n_checks++;
        if (x !== 10'd96 || y !== 10'd96) $display("FAIL rd_sprite3: got %0d,%0d expected 96,96", x, y);
        else n_pass++;
        n_checks++;
        if (rd_x3 !== 10'd0 || rd_y3 !== 10'd0) $display("FAIL rd_oob3: got %0d,%0d expected 0,0", rd_x3, rd_y3);
        else n_pass++;
        read_pos(2'd2, x, y);
        n_checks++;
        if (rd_x3 !== 10'd64 || rd_y3 !== 10'd64) $display("FAIL rd_sprite2_n3: got %0d,%0d expected 64,64", rd_x3, rd_y3);
        else n_pass++;
    endtask

    task automatic test_single_step();
        int d, b;
        logic [9:0] x, y;
        run = 1'b1; fps = 4'd0;
        pulse(20, d, b);
        n_checks++;
        if (b !== 9) $display("FAIL single_busy_len: got %0d expected 9", b);
        else n_pass++;
        n_checks++;
        if (d !== 1) $display("FAIL single_done_cnt: got %0d expected 1", d);
        else n_pass++;
        read_pos(2'd0, x, y);
        n_checks++;
        if (x !== 10'd1 || y !== 10'd1) $display("FAIL single_sprite0: got %0d,%0d expected 1,1", x, y);
        else n_pass++;
        read_pos(2'd1, x, y);
        n_checks++;
        if (x !== 10'd34 || y !== 10'd34) $display("FAIL single_sprite1: got %0d,%0d expected 34,34", x, y);
        else n_pass++;
        read_pos(2'd3, x, y);
        n_checks++;
        if (x !== 10'd100 || y !== 10'd100) $display("FAIL single_sprite3: got %0d,%0d expected 100,100", x, y);
        else n_pass++;
    endtask

    task automatic test_divider();
        int d, b;
        logic [9:0] x, y;
        do_reset();
        run = 1'b1; fps = 4'd2;
        for (int i = 0; i < 6; i++) begin
            pulse(1000, d, b);
            n_checks++;
            if (d !== ((i == 2 || i == 5) ? 1 : 0))
                $display("FAIL div_tick%0d: got %0d dones expected %0d", i + 1, d, (i == 2 || i == 5) ? 1 : 0);
            else n_pass++;
        end
        read_pos(2'd1, x, y);
        n_checks++;
        if (x !== 10'd36 || y !== 10'd36) $display("FAIL div_sprite1: got %0d,%0d expected 36,36", x, y);
        else n_pass++;
        // cnt climbs to 2 under fps=3, then fps drops to 1 below it.
        fps = 4'd3;
        pulse(20, d, b);
        pulse(20, b, d);
        n_checks++;
        if (d !== 0 || b !== 0) $display("FAIL div_pre_shrink: got %0d,%0d dones expected 0,0", b, d);
        else n_pass++;
        fps = 4'd1;
        pulse(20, d, b);
        n_checks++;
        if (d !== 1) $display("FAIL div_shrink_step: got %0d dones expected 1", d);
        else n_pass++;
        pulse(20, d, b);
        n_checks++;
        if (d !== 0) $display("FAIL div_after_shrink: got %0d dones expected 0", d);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int d, b;
        logic [9:0] x, y;
        do_reset();
        run = 1'b1; fps = 4'd0;
        for (int n = 1; n <= 209; n++) begin
            pulse(12, d, b);
            if (n == 92) begin
                read_pos(2'd3, x, y);
                n_checks++;
                if (x !== 10'd464 || y !== 10'd464) $display("FAIL bounce_s92: got %0d,%0d expected 464,464", x, y);
                else n_pass++;
            end
            if (n == 132) begin
                read_pos(2'd3, x, y);
                n_checks++;
                if (x !== 10'd624 || y !== 10'd304) $display("FAIL bounce_s132: got %0d,%0d expected 624,304", x, y);
                else n_pass++;
                read_pos(2'd0, x, y);
                n_checks++;
                if (x !== 10'd132 || y !== 10'd132) $display("FAIL bounce_s132_sp0: got %0d,%0d expected 132,132", x, y);
                else n_pass++;
            end
            if (n == 133) begin
                read_pos(2'd3, x, y);
                n_checks++;
                if (x !== 10'd620 || y !== 10'd300) $display("FAIL bounce_s133: got %0d,%0d expected 620,300", x, y);
                else n_pass++;
            end
            if (n == 208) begin
                read_pos(2'd3, x, y);
                n_checks++;
                if (x !== 10'd320 || y !== 10'd0) $display("FAIL bounce_s208: got %0d,%0d expected 320,0", x, y);
                else n_pass++;
            end
            if (n == 209) begin
                read_pos(2'd3, x, y);
                n_checks++;
                if (x !== 10'd316 || y !== 10'd4) $display("FAIL bounce_s209: got %0d,%0d expected 316,4", x, y);
                else n_pass++;
            end
        end
    endtask

    task automatic test_overrun_gating();
        int d, b, dsum, bsum;
        logic [9:0] x, y;
        do_reset();
        run = 1'b1; fps = 4'd0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL ovr_busy: got %b expected 1", busy);
        else n_pass++;
        tick();
        tick();
        frame_tick = 1'b1;
        #1;
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL ovr_pulse: got %b expected 1", overrun);
        else n_pass++;
        tick();
        frame_tick = 1'b0;
        #1;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", overrun);
        else n_pass++;
        dsum = 0;
        for (int i = 0; i < 20; i++) begin
            if (step_done) dsum++;
            tick();
        end
        n_checks++;
        if (dsum !== 1) $display("FAIL ovr_done_cnt: got %0d expected 1", dsum);
        else n_pass++;
        read_pos(2'd0, x, y);
        n_checks++;
        if (x !== 10'd1 || y !== 10'd1) $display("FAIL ovr_sprite0: got %0d,%0d expected 1,1", x, y);
        else n_pass++;
        // Ticks with run low must be ignored entirely.
        run = 1'b0;
        dsum = 0; bsum = 0;
        for (int i = 0; i < 5; i++) begin
            pulse(10, d, b);
            dsum += d;
            bsum += b;
        end
        n_checks++;
        if (bsum !== 0 || dsum !== 0) $display("FAIL gate_busy_done: got %0d,%0d expected 0,0", bsum, dsum);
        else n_pass++;
        read_pos(2'd0, x, y);
        n_checks++;
        if (x !== 10'd1 || y !== 10'd1) $display("FAIL gate_sprite0: got %0d,%0d expected 1,1", x, y);
        else n_pass++;
        // run dropping mid-sequence lets the sequence finish.
        run = 1'b1;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        run = 1'b0;
        dsum = 0;
        for (int i = 0; i < 20; i++) begin
            if (step_done) dsum++;
            tick();
        end
        n_checks++;
        if (dsum !== 1) $display("FAIL runfall_done: got %0d expected 1", dsum);
        else n_pass++;
        read_pos(2'd0, x, y);
        n_checks++;
        if (x !== 10'd2 || y !== 10'd2) $display("FAIL runfall_sprite0: got %0d,%0d expected 2,2", x, y);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dsum;
        logic [9:0] x, y;
        do_reset();
        run = 1'b1; fps = 4'd0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || step_done !== 1'b0) $display("FAIL rstmid_idle: got %b%b expected 00", busy, step_done);
        else n_pass++;
        rd_idx = 2'd3;
        tick();
        tick();
        n_checks++;
        if (rd_x !== 10'd96 || rd_y !== 10'd96) $display("FAIL rstmid_sprite3: got %0d,%0d expected 96,96", rd_x, rd_y);
        else n_pass++;
        dsum = 0;
        for (int i = 0; i < 15; i++) begin
            if (step_done) dsum++;
            tick();
        end
        n_checks++;
        if (dsum !== 0) $display("FAIL rstmid_no_done: got %0d expected 0", dsum);
        else n_pass++;
        read_pos(2'd0, x, y);
        n_checks++;
        if (x !== 10'd0 || y !== 10'd0) $display("FAIL rstmid_sprite0: got %0d,%0d expected 0,0", x, y);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read_port();
        test_single_step();
        test_divider();
        test_bounce();
        test_overrun_gating();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_motion_scheduler.md
Name: sprite_motion_scheduler

Overview:
Frame-synchronous scheduler that owns the positions of NUM_SPRITES bouncing sprites on the 640x480 display. On each accepted vertical-blank tick, it sequences one position update per sprite through a single shared bounce/step datapath. Per-axis edge reflection is applied during the update. A registered read port lets the pixel renderer fetch any sprite's current position.

Parameters:
NUM_SPRITES, 4, number of sprites held; IDX_W = clog2(NUM_SPRITES), minimum 1
H_ACTIVE, 640, visible width in pixels
V_ACTIVE, 480, visible height in pixels
SPRITE_W, 16, sprite width; X_MAX = H_ACTIVE - SPRITE_W
SPRITE_H, 16, sprite height; Y_MAX = V_ACTIVE - SPRITE_H
DIV_WIDTH, 4, width of frames_per_step

Ports:
clk  in  1  pixel-domain clock
rst  in  1  reset; synchronous, active-high
frame_tick  in  1  one-cycle pulse at start of vertical blank
run  in  1  1 = accept frame_tick; 0 = ticks ignored, frame counter holds
frames_per_step  in  DIV_WIDTH  a step runs every (frames_per_step+1) accepted ticks
rd_idx  in  IDX_W  renderer read index
rd_x  out  10  x of sprite rd_idx, registered, 1-cycle latency
rd_y  out  10  y of sprite rd_idx, registered, 1-cycle latency
busy  out  1  high while an update sequence is in progress
step_done  out  1  one-cycle pulse when all sprites have been updated
overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Per-sprite state: x[9:0], y[9:0], dx (1 = right), dy (1 = down).
- Speed of sprite i is the constant v_i = i+1 pixels per step.
- Reset values for sprite i: x = y = 32*i, dx = dy = 1.
- Reset values for control and outputs: frame counter 0, FSM IDLE, busy 0, step_done 0, overrun 0, rd_x 0, rd_y 0.
- FSM states: IDLE, FETCH, UPDATE, DONE.
- IDLE: if frame_tick && run:
  - if cnt == frames_per_step: cnt <= 0, k <= 0, go to FETCH;
  - otherwise cnt <= cnt+1.
- FETCH: latch x, y, dx, dy of sprite k into working registers; go to UPDATE.
- UPDATE: write the stepped values back to sprite k.
  - If k == NUM_SPRITES-1, go to DONE; otherwise k <= k+1 and go to FETCH.
- DONE: step_done = 1 for this cycle only; go to IDLE.
- busy = (state != IDLE), so busy is high for 2*NUM_SPRITES+1 cycles, starting the cycle after the accepted tick.
- Axis step rule (computed in 11 bits, no wrap):
  - Moving positive: if p + v >= MAX, then p <= MAX and the direction flips to 0; else p <= p + v.
  - Moving negative: if p <= v, then p <= 0 and the direction flips to 1; else p <= p - v.
  - x and y reflect independently.
- Read port: rd_x/rd_y <= array[rd_idx] every cycle.
  - rd_idx >= NUM_SPRITES returns 0/0.
  - A read of sprite k in the same cycle as its UPDATE write returns the old value.
- frame_tick while busy: tick is ignored, cnt is unchanged, overrun pulses that cycle. This applies regardless of run.
- run falling mid-sequence: the sequence completes normally; only new ticks are gated.
- frames_per_step changes take effect at the next tick compare. If cnt > frames_per_step at that compare, the step runs and cnt clears.
- rst mid-sequence: next cycle all sprites are at reset positions, FSM IDLE, no step_done.
- rst takes priority over every other input.

Decomposition:
- Package sprite_pkg holds:
  - H_ACTIVE, V_ACTIVE, SPRITE_W, SPRITE_H defaults;
  - state enum {IDLE, FETCH, UPDATE, DONE};
  - sprite record typedef {x, y, dx, dy};
  - function speed(i) = i+1;
  - function reset_pos(i) = 32*i.
- Sub-module sprite_axis_step: combinational one-axis bounce with inputs p, dir, v, max and outputs p_next, dir_next. It is instantiated twice, once for x and once for y.

Test Plan:
- Single step: rst, run=1, frames_per_step=0, one frame_tick -> busy high for 9 cycles, then step_done pulse; sprite 0 = (1,1), sprite 3 = (100,100).
- Frame divider: frames_per_step=2, 6 ticks spaced 1000 cycles apart -> exactly 2 step_done pulses, on the 3rd and 6th ticks; sprite 1 = (36,36).
- Edge bounce: frames_per_step=0, 132 steps -> sprite 3 x = 624 with dx=0; step 133 -> x = 620. y reaches 464 at step 92 and dy flips, so after step 132 y = 304. Sprite 0 is still moving positive at x = 132.
- Overrun and gating: frame_tick 3 cycles after an accepted tick -> overrun pulse, and still only one step_done. With run=0, 5 ticks -> no busy and positions unchanged.
- Reset mid-sequence: assert rst for 1 cycle while k=2 -> no step_done; rd_idx=3 reads (96,96) two cycles later.
- Read port: rd_idx=1 after reset -> rd_x=32 one cycle later; rd_idx=3 with NUM_SPRITES=3 -> 0/0.
